// File: rtl/regex_cmd_sequencer.sv
// Command sequencer between a software register file and a regex coprocessor.
// Decodes software commands into instruction-memory accesses, core start/reset
// sequences and status/result register updates.
// Optional feature: define REGEX_CMD_SEQ_ELAPSED_CLOCK_EN to build the run-length
// counter; without it READ_ELAPSED_CLOCK returns 0.
module regex_cmd_sequencer #(
    parameter int REG_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int RESET_CYCLES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_WIDTH-1:0]      cmd_reg,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [REG_WIDTH-1:0]      address_reg,
    input  logic [REG_WIDTH-1:0]      data_in_reg,
    output logic [REG_WIDTH-1:0]      data_out_reg,
    output logic [REG_WIDTH-1:0]      status_reg,
    output logic                      mem_valid,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]      mem_wdata,
    input  logic                      mem_ready,
    input  logic [REG_WIDTH-1:0]      mem_rdata,
    output logic                      core_start,
    output logic                      core_rst,
    input  logic                      core_done,
    input  logic                      core_accepted,
    input  logic [REG_WIDTH-1:0]      fifo_count
);

    localparam logic [REG_WIDTH-1:0] CMD_NOP        = REG_WIDTH'(0);
    localparam logic [REG_WIDTH-1:0] CMD_WRITE      = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] CMD_READ       = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] CMD_START      = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] CMD_RESET      = REG_WIDTH'(4);
    localparam logic [REG_WIDTH-1:0] CMD_RD_ELAPSED = REG_WIDTH'(5);
    localparam logic [REG_WIDTH-1:0] CMD_RESTART    = REG_WIDTH'(6);
    localparam logic [REG_WIDTH-1:0] CMD_RD_FIFO    = REG_WIDTH'(7);

    localparam logic [REG_WIDTH-1:0] ST_IDLE     = REG_WIDTH'(0);
    localparam logic [REG_WIDTH-1:0] ST_RUNNING  = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] ST_ACCEPTED = REG_WIDTH'(2);
    localparam logic [REG_WIDTH-1:0] ST_REJECTED = REG_WIDTH'(3);
    localparam logic [REG_WIDTH-1:0] ST_ERROR    = REG_WIDTH'(4);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_MEM_WR, S_MEM_RD, S_RUN, S_RESET} state_t;

    state_t          state;
    state_t          state_next;
    logic [RC_W-1:0] rst_cnt;
    logic            reset_cmd;
    logic            accept;
    logic            run_done;
    logic            restart_ok;
    logic            unused_addr_bits;

    // RESET is honoured in any state; everything else only when idle.
    // The core_start cycle is excluded so a stale done from the previous run is not taken.
    assign reset_cmd        = cmd_valid && (cmd_reg == CMD_RESET);
    assign accept           = cmd_valid && (state == S_IDLE) && !reset_cmd;
    assign run_done         = (state == S_RUN) && core_done && !core_start;
    assign restart_ok       = (status_reg == ST_ACCEPTED) || (status_reg == ST_REJECTED);
    assign cmd_ready        = (state == S_IDLE);
    assign core_rst         = rst || (state == S_RESET);
    assign unused_addr_bits = ^address_reg[REG_WIDTH-1:MEM_ADDR_WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; a RESET command overrides every other transition.
    always_comb begin
        state_next = state;
        if (reset_cmd) begin
            state_next = S_RESET;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_reg)
                            CMD_WRITE:   state_next = S_MEM_WR;
                            CMD_READ:    state_next = S_MEM_RD;
                            CMD_START:   state_next = S_RUN;
                            CMD_RESTART: if (restart_ok) state_next = S_RUN;
                            default:     state_next = S_IDLE;
                        endcase
                    end
                end
                S_MEM_WR, S_MEM_RD: if (mem_ready) state_next = S_IDLE;
                S_RUN:              if (run_done) state_next = S_IDLE;
                S_RESET:            if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_next = S_IDLE;
                default:            state_next = S_IDLE;
            endcase
        end
    end

    // Counts the cycles spent in S_RESET so core_rst lasts exactly RESET_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || reset_cmd)      rst_cnt <= '0;
        else if (state == S_RESET) rst_cnt <= rst_cnt + RC_W'(1);
    end

`ifdef REGEX_CMD_SEQ_ELAPSED_CLOCK_EN
    logic [REG_WIDTH-1:0] elapsed;

    // Run-length counter: cleared by START, kept across RESTART, frozen on done, saturating.
    always_ff @(posedge clk) begin
        if (rst || reset_cmd) begin
            elapsed <= '0;
        end else if (accept && (cmd_reg == CMD_START)) begin
            elapsed <= '0;
        end else if ((state == S_RUN) && !run_done && (elapsed != '1)) begin
            elapsed <= elapsed + REG_WIDTH'(1);
        end
    end
`endif

    // Registered outputs: memory request, core start pulse, status and read-back data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_start   <= 1'b0;
            status_reg   <= ST_IDLE;
            data_out_reg <= '0;
        end else begin
            core_start <= 1'b0;
            if (reset_cmd) begin
                mem_valid    <= 1'b0;
                mem_we       <= 1'b0;
                status_reg   <= ST_IDLE;
                data_out_reg <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            case (cmd_reg)
                                CMD_NOP: ;
                                CMD_WRITE, CMD_READ: begin
                                    mem_valid <= 1'b1;
                                    mem_we    <= (cmd_reg == CMD_WRITE);
                                    mem_addr  <= address_reg[MEM_ADDR_WIDTH-1:0];
                                    mem_wdata <= data_in_reg;
                                end
                                CMD_START: begin
                                    core_start <= 1'b1;
                                    status_reg <= ST_RUNNING;
                                end
                                CMD_RESTART: begin
                                    if (restart_ok) begin
                                        core_start <= 1'b1;
                                        status_reg <= ST_RUNNING;
                                    end else begin
                                        status_reg <= ST_ERROR;
                                    end
                                end
                                CMD_RD_ELAPSED: begin
`ifdef REGEX_CMD_SEQ_ELAPSED_CLOCK_EN
                                    data_out_reg <= elapsed;
`else
                                    data_out_reg <= '0;
`endif
                                end
                                CMD_RD_FIFO: data_out_reg <= fifo_count;
                                default:     status_reg   <= ST_ERROR;
                            endcase
                        end
                    end
                    S_MEM_WR, S_MEM_RD: begin
                        if (mem_ready) begin
                            mem_valid <= 1'b0;
                            mem_we    <= 1'b0;
                            if (state == S_MEM_RD) data_out_reg <= mem_rdata;
                        end
                    end
                    S_RUN: begin
                        if (run_done) status_reg <= core_accepted ? ST_ACCEPTED : ST_REJECTED;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regex_cmd_sequencer.sv
// Directed bench for regex_cmd_sequencer: linear command sequence with
// hand-computed expectations, checked by immediate assertions.
module tb_regex_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_reg;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] address_reg;
    logic [31:0] data_in_reg;
    logic [31:0] data_out_reg;
    logic [31:0] status_reg;
    logic        mem_valid;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        core_start;
    logic        core_rst;
    logic        core_done;
    logic        core_accepted;
    logic [31:0] fifo_count;

    int total = 0;
    int bad   = 0;

`ifdef REGEX_CMD_SEQ_ELAPSED_CLOCK_EN
    localparam logic [31:0] EXP_EL_RUN1 = 32'd10;
    localparam logic [31:0] EXP_EL_RUN2 = 32'd12;
`else
    localparam logic [31:0] EXP_EL_RUN1 = 32'd0;
    localparam logic [31:0] EXP_EL_RUN2 = 32'd0;
`endif

    regex_cmd_sequencer #(
        .REG_WIDTH(32),
        .MEM_ADDR_WIDTH(9),
        .RESET_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_reg(cmd_reg),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .address_reg(address_reg),
        .data_in_reg(data_in_reg),
        .data_out_reg(data_out_reg),
        .status_reg(status_reg),
        .mem_valid(mem_valid),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .core_start(core_start),
        .core_rst(core_rst),
        .core_done(core_done),
        .core_accepted(core_accepted),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle command pulse; returns just after the accepting edge.
    task automatic issue(input logic [31:0] code);
        cmd_reg   = code;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_reg = '0; cmd_valid = 1'b0; address_reg = '0; data_in_reg = '0;
        mem_ready = 1'b0; mem_rdata = '0; core_done = 1'b0; core_accepted = 1'b0; fifo_count = '0;
        step();
        step();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_status", status_reg, 0);
        chk("rst_mem_valid", mem_valid, 0);
        rst = 1'b0;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_core_rst_low", core_rst, 0);
        chk("rst_data_out", data_out_reg, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_start", core_start, 0);

        // WRITE with mem_ready in the third request cycle
        address_reg = 32'h1F5; data_in_reg = 32'hDEADBEEF;
        issue(32'd1);
        chk("wr_valid1", mem_valid, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 9'h1F5);
        chk("wr_wdata1", mem_wdata, 32'hDEADBEEF);
        chk("wr_busy", cmd_ready, 0);
        address_reg = '0; data_in_reg = '0;
        step();
        chk("wr_valid2", mem_valid, 1);
        chk("wr_wdata2", mem_wdata, 32'hDEADBEEF);
        chk("wr_addr2", mem_addr, 9'h1F5);
        step();
        mem_ready = 1'b1;
        chk("wr_valid3", mem_valid, 1);
        step();
        mem_ready = 1'b0;
        chk("wr_valid_end", mem_valid, 0);
        chk("wr_ready_back", cmd_ready, 1);
        chk("wr_status", status_reg, 0);

        // READ completing in a single cycle
        address_reg = 32'h012;
        issue(32'd2);
        chk("rd_valid", mem_valid, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 9'h012);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        step();
        mem_ready = 1'b0;
        chk("rd_data", data_out_reg, 32'hCAFE0001);
        chk("rd_valid_end", mem_valid, 0);
        chk("rd_ready", cmd_ready, 1);

        // stray mem_ready while idle is ignored
        mem_ready = 1'b1; mem_rdata = 32'h55;
        step();
        mem_ready = 1'b0;
        chk("stray_valid", mem_valid, 0);
        chk("stray_data", data_out_reg, 32'hCAFE0001);

        issue(32'd0);
        chk("nop_status", status_reg, 0);
        chk("nop_ready", cmd_ready, 1);

        // START, early done ignored, WRITE dropped mid-run, done 10 cycles after pulse
        issue(32'd3);
        chk("st_pulse", core_start, 1);
        chk("st_status", status_reg, 1);
        chk("st_ready", cmd_ready, 0);
        core_done = 1'b1; core_accepted = 1'b0;
        step();
        core_done = 1'b0;
        chk("st_pulse_gone", core_start, 0);
        chk("st_early_done", status_reg, 1);
        address_reg = 32'h77;
        issue(32'd1);
        chk("run_wr_dropped", mem_valid, 0);
        chk("run_status", status_reg, 1);
        repeat (8) step();
        core_done = 1'b1; core_accepted = 1'b1;
        step();
        core_done = 1'b0; core_accepted = 1'b0;
        chk("run_accepted", status_reg, 2);
        chk("run_ready", cmd_ready, 1);
        issue(32'd5);
        chk("elapsed_run1", data_out_reg, EXP_EL_RUN1);
        chk("elapsed_status", status_reg, 2);

        // rejected run of 5 cycles, then RESTART run of 7 cycles
        issue(32'd3);
        repeat (5) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("rej_status", status_reg, 3);
        issue(32'd6);
        chk("rs_pulse", core_start, 1);
        chk("rs_status", status_reg, 1);
        repeat (7) step();
        core_done = 1'b1; core_accepted = 1'b1;
        step();
        core_done = 1'b0; core_accepted = 1'b0;
        chk("rs_accepted", status_reg, 2);
        issue(32'd5);
        chk("elapsed_run2", data_out_reg, EXP_EL_RUN2);

        fifo_count = 32'h33;
        issue(32'd7);
        chk("fifo_count", data_out_reg, 32'h33);
        chk("fifo_status", status_reg, 2);

        // RESET during a READ that never completes
        issue(32'd2);
        chk("rr_valid", mem_valid, 1);
        issue(32'd4);
        chk("rr_valid_drop", mem_valid, 0);
        chk("rr_core_rst", core_rst, 1);
        chk("rr_status", status_reg, 0);
        chk("rr_data", data_out_reg, 0);
        chk("rr_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_core_rst_hold", core_rst, 1);
        end
        step();
        chk("rr_core_rst_end", core_rst, 0);
        chk("rr_ready_back", cmd_ready, 1);

        // RESTART without a verdict, NOP keeps ERROR
        issue(32'd6);
        chk("rsx_status", status_reg, 4);
        chk("rsx_no_start", core_start, 0);
        chk("rsx_ready", cmd_ready, 1);
        issue(32'd0);
        chk("err_sticky_nop", status_reg, 4);
        issue(32'd4);
        repeat (4) step();
        chk("err_cleared_reset", status_reg, 0);
        chk("err_reset_ready", cmd_ready, 1);

        // undefined code, then START clears ERROR
        issue(32'd9);
        chk("undef_status", status_reg, 4);
        chk("undef_ready", cmd_ready, 1);
        issue(32'd3);
        chk("err_cleared_start", status_reg, 1);
        chk("err_start_pulse", core_start, 1);

        // core_done and RESET in the same cycle: RESET wins
        step();
        core_done = 1'b1; core_accepted = 1'b1;
        cmd_reg = 32'd4; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0; core_done = 1'b0; core_accepted = 1'b0;
        chk("race_status", status_reg, 0);
        chk("race_core_rst", core_rst, 1);
        repeat (4) step();
        chk("race_ready", cmd_ready, 1);
        chk("race_status_end", status_reg, 0);

        // rst in the middle of a run
        issue(32'd3);
        step();
        rst = 1'b1;
        step();
        chk("rstrun_status", status_reg, 0);
        chk("rstrun_core_rst", core_rst, 1);
        rst = 1'b0;
        step();
        chk("rstrun_ready", cmd_ready, 1);
        chk("rstrun_start", core_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
